// File: rtl/wfg_pat_sequencer.sv
// Pattern cycle sequencer: prescaled subcycle timing, sync pulses,
// continuous or fixed-length burst runs with shadowed configuration.
module wfg_pat_sequencer #(
  parameter int PRESC_WIDTH = 16,
  parameter int FRAME_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ctrl_en_q_i,
  input  logic                   ctrl_mode_q_i,
  input  logic                   start_i,
  input  logic [PRESC_WIDTH-1:0] cfg_presc_q_i,
  input  logic [7:0]             cfg_subcycles_q_i,
  input  logic [FRAME_WIDTH-1:0] cfg_frames_q_i,
  output logic                   pat_sync_o,
  output logic [7:0]             pat_subcycle_cnt_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [FRAME_WIDTH-1:0] frame_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = 1;
  localparam logic [FRAME_WIDTH-1:0] FRAME_ONE = 1;

  state_t                 state;
  logic [PRESC_WIDTH-1:0] presc_cnt;
  logic [PRESC_WIDTH-1:0] presc_sh;
  logic [7:0]             sub_cnt;
  logic [7:0]             sub_sh;
  logic [FRAME_WIDTH-1:0] frame_cnt;
  logic [FRAME_WIDTH-1:0] frames_sh;
  logic                   mode_q;
  logic                   sync_q;
  logic                   busy_q;
  logic                   done_q;

  logic trigger;
  logic sub_end;
  logic cyc_end;
  logic last;

  // Run trigger and end-of-subcycle / end-of-cycle / end-of-burst decode
  always_comb begin
    trigger = ctrl_en_q_i & (~ctrl_mode_q_i | start_i);
    sub_end = (presc_cnt == presc_sh);
    cyc_end = sub_end & (sub_cnt == sub_sh);
    last    = cyc_end & mode_q & (frame_cnt == frames_sh);
  end

  // Sequencer FSM with all counters and outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      presc_cnt <= '0;
      presc_sh  <= '0;
      sub_cnt   <= '0;
      sub_sh    <= '0;
      frame_cnt <= '0;
      frames_sh <= '0;
      mode_q    <= 1'b0;
      sync_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sync_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          presc_cnt <= '0;
          sub_cnt   <= '0;
          frame_cnt <= '0;
          busy_q    <= 1'b0;
          if (trigger) begin
            state     <= RUN;
            sync_q    <= 1'b1;
            busy_q    <= 1'b1;
            mode_q    <= ctrl_mode_q_i;
            presc_sh  <= cfg_presc_q_i;
            sub_sh    <= cfg_subcycles_q_i;
            frames_sh <= cfg_frames_q_i;
          end
        end
        RUN: begin
          if (!ctrl_en_q_i) begin
            state     <= IDLE;
            presc_cnt <= '0;
            sub_cnt   <= '0;
            frame_cnt <= '0;
            busy_q    <= 1'b0;
          end else if (cyc_end) begin
            presc_cnt <= '0;
            sub_cnt   <= '0;
            frame_cnt <= frame_cnt + FRAME_ONE;
            if (last) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              sync_q    <= 1'b1;
              presc_sh  <= cfg_presc_q_i;
              sub_sh    <= cfg_subcycles_q_i;
              frames_sh <= cfg_frames_q_i;
            end
          end else if (sub_end) begin
            presc_cnt <= '0;
            sub_cnt   <= sub_cnt + 8'd1;
          end else begin
            presc_cnt <= presc_cnt + PRESC_ONE;
          end
        end
        DONE: begin
          state     <= IDLE;
          busy_q    <= 1'b0;
          frame_cnt <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign pat_sync_o         = sync_q;
  assign pat_subcycle_cnt_o = sub_cnt;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign frame_cnt_o        = frame_cnt;

endmodule

// File: tb/tb_wfg_pat_sequencer.sv
// Scoreboard bench for wfg_pat_sequencer: directed runs push
// per-cycle expectations, a negedge monitor pops and compares.
module tb_wfg_pat_sequencer;

  localparam int PW = 16;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          mode;
  logic          start;
  logic [PW-1:0] presc;
  logic [7:0]    subs;
  logic [FW-1:0] frames;
  logic          pat_sync;
  logic [7:0]    sub_cnt;
  logic          busy;
  logic          done;
  logic [FW-1:0] frame_cnt;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int            cyc;
    string         tag;
    logic          sync;
    logic [7:0]    sub;
    logic          busy;
    logic          done;
    logic [FW-1:0] frame;
  } exp_t;

  exp_t q[$];

  wfg_pat_sequencer #(
    .PRESC_WIDTH(PW),
    .FRAME_WIDTH(FW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ctrl_en_q_i       (en),
    .ctrl_mode_q_i     (mode),
    .start_i           (start),
    .cfg_presc_q_i     (presc),
    .cfg_subcycles_q_i (subs),
    .cfg_frames_q_i    (frames),
    .pat_sync_o        (pat_sync),
    .pat_subcycle_cnt_o(sub_cnt),
    .busy_o            (busy),
    .done_o            (done),
    .frame_cnt_o       (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int c, input string tag,
                           input logic s, input logic [7:0] sb,
                           input logic b, input logic d,
                           input logic [FW-1:0] f);
    exp_t e;
    e.cyc   = c;
    e.tag   = tag;
    e.sync  = s;
    e.sub   = sb;
    e.busy  = b;
    e.done  = d;
    e.frame = f;
    q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    checks++;
    if (pat_sync !== 1'b0 || sub_cnt !== 8'd0 || busy !== 1'b0 ||
        done !== 1'b0 || frame_cnt !== '0) begin
      errors++;
      $display("FAIL %s: got sync=%b sub=%0d busy=%b done=%b frame=%0d, want all 0",
               tag, pat_sync, sub_cnt, busy, done, frame_cnt);
    end
  endtask

  // Monitor: compare DUT outputs against the expectation for this cycle
  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d skipped (now %0d)",
               e.tag, e.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      checks++;
      if (pat_sync !== e.sync || sub_cnt !== e.sub || busy !== e.busy ||
          done !== e.done || frame_cnt !== e.frame) begin
        errors++;
        $display("FAIL %s cyc=%0d: got sync=%b sub=%0d busy=%b done=%b frame=%0d, want sync=%b sub=%0d busy=%b done=%b frame=%0d",
                 e.tag, cyc, pat_sync, sub_cnt, busy, done, frame_cnt,
                 e.sync, e.sub, e.busy, e.done, e.frame);
      end
    end
  end

  initial begin
    int n;
    int s;
    int m;
    rst_n  = 1'b0;
    en     = 1'b0;
    mode   = 1'b0;
    start  = 1'b0;
    presc  = '0;
    subs   = '0;
    frames = '0;
    #1 chk_zero("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = cyc;
    expect_at(n + 1, "idle", 0, 0, 0, 0, 0);
    expect_at(n + 2, "idle", 0, 0, 0, 0, 0);
    wait_to(n + 3);

    // Continuous, presc=1, subcycles=2; mode flipped mid-run is ignored
    presc  = 16'd1;
    subs   = 8'd2;
    frames = '0;
    mode   = 1'b0;
    en     = 1'b1;
    s = cyc + 1;
    for (int k = 0; k < 18; k++)
      expect_at(s + k, "cont", (k % 6) == 0, 8'((k % 6) / 2),
                1, 0, FW'(k / 6));
    expect_at(s + 18, "cont_off", 0, 0, 0, 0, 0);
    wait_to(s + 2);
    mode = 1'b1;
    wait_to(s + 17);
    en = 1'b0;
    wait_to(s + 19);

    // Burst, presc=0, subcycles=3, frames=1; start in RUN/DONE ignored
    mode   = 1'b1;
    presc  = 16'd0;
    subs   = 8'd3;
    frames = FW'(1);
    en     = 1'b1;
    start  = 1'b1;
    s = cyc + 1;
    for (int k = 0; k < 8; k++)
      expect_at(s + k, "burst", (k % 4) == 0, 8'(k % 4),
                1, 0, FW'(k / 4));
    expect_at(s + 8, "burst_done", 0, 0, 0, 1, FW'(2));
    expect_at(s + 9, "burst_idle", 0, 0, 0, 0, 0);
    expect_at(s + 10, "burst_idle", 0, 0, 0, 0, 0);
    wait_to(s);
    start = 1'b0;
    wait_to(s + 3);
    start = 1'b1;
    wait_to(s + 4);
    start = 1'b0;
    wait_to(s + 8);
    start = 1'b1;
    wait_to(s + 9);
    start = 1'b0;
    wait_to(s + 11);

    // Shadowed prescaler: 1 -> 4 written mid cycle 0
    mode  = 1'b0;
    presc = 16'd1;
    subs  = 8'd0;
    en    = 1'b1;
    s = cyc + 1;
    for (int k = 0; k < 13; k++)
      expect_at(s + k, "shadow",
                (k == 0 || k == 2 || k == 7 || k == 12), 8'd0, 1, 0,
                (k < 2) ? FW'(0) : (k < 7) ? FW'(1) :
                (k < 12) ? FW'(2) : FW'(3));
    expect_at(s + 13, "shadow_off", 0, 0, 0, 0, 0);
    wait_to(s);
    presc = 16'd4;
    wait_to(s + 12);
    en = 1'b0;
    wait_to(s + 14);

    // Burst frames=3 aborted by enable drop after 2 cycles
    mode   = 1'b1;
    presc  = 16'd1;
    subs   = 8'd1;
    frames = FW'(3);
    en     = 1'b1;
    start  = 1'b1;
    s = cyc + 1;
    for (int k = 0; k < 8; k++)
      expect_at(s + k, "abort_run", (k % 4) == 0, 8'((k % 4) / 2),
                1, 0, FW'(k / 4));
    for (int k = 8; k < 11; k++)
      expect_at(s + k, "abort_idle", 0, 0, 0, 0, 0);
    wait_to(s);
    start = 1'b0;
    wait_to(s + 5);
    start = 1'b1;
    wait_to(s + 6);
    start = 1'b0;
    wait_to(s + 7);
    en = 1'b0;
    wait_to(s + 11);

    // Async reset mid-subcycle with presc=7, then resume
    mode  = 1'b0;
    presc = 16'd7;
    subs  = 8'd1;
    en    = 1'b1;
    s = cyc + 1;
    for (int k = 0; k < 4; k++)
      expect_at(s + k, "pre_rst", k == 0, 8'd0, 1, 0, 0);
    wait_to(s + 3);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m = cyc;
    for (int k = 0; k < 9; k++)
      expect_at(m + 1 + k, "rst_resume", k == 0, 8'(k / 8), 1, 0, 0);
    expect_at(m + 10, "rst_off", 0, 0, 0, 0, 0);
    wait_to(m + 9);
    en = 1'b0;
    wait_to(m + 11);

    // All-zero config: sync every clock, frame counter wraps
    mode   = 1'b0;
    presc  = 16'd0;
    subs   = 8'd0;
    frames = '0;
    en     = 1'b1;
    s = cyc + 1;
    for (int k = 0; k < 20; k++)
      expect_at(s + k, "zero_cfg", 1, 8'd0, 1, 0, FW'(k));
    expect_at(s + 20, "zero_off", 0, 0, 0, 0, 0);
    wait_to(s + 19);
    en = 1'b0;
    wait_to(s + 21);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never compared",
               e.tag, e.cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wfg_pat_sequencer.md
WFG_PAT_SEQUENCER -- requirements
Module: wfg_pat_sequencer

Interface
REQ-001 SHALL have parameter PRESC_WIDTH, default 16, bit width of the prescaler counter and its configuration.
REQ-002 SHALL have parameter FRAME_WIDTH, default 16, bit width of the burst frame counter and its configuration.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ctrl_en_q_i  input  1  sequencer enable.
REQ-006 ctrl_mode_q_i  input  1  0 = continuous, 1 = burst.
REQ-007 start_i  input  1  single-clock burst trigger; ignored in continuous mode.
REQ-008 cfg_presc_q_i  input  PRESC_WIDTH  subcycle length minus 1, in clk periods.
REQ-009 cfg_subcycles_q_i  input  8  subcycles per pattern cycle minus 1.
REQ-010 cfg_frames_q_i  input  FRAME_WIDTH  pattern cycles per burst minus 1.
REQ-011 pat_sync_o  output  1  one-clock pulse at the start of each pattern cycle; drives the pattern driver's sync input.
REQ-012 pat_subcycle_cnt_o  output  8  current subcycle index; drives the pattern driver's subcycle input.
REQ-013 busy_o  output  1  high while state is RUN.
REQ-014 done_o  output  1  one-clock pulse when a burst completes.
REQ-015 frame_cnt_o  output  FRAME_WIDTH  completed pattern cycles in the current run.

Function
REQ-016 SHALL implement three states: IDLE, RUN, DONE.
REQ-017 In IDLE, presc_cnt, subcycle, frame counter, pat_sync_o, pat_subcycle_cnt_o and busy_o SHALL be held at 0.
REQ-018 IDLE->RUN SHALL occur when ctrl_en_q_i=1 and either ctrl_mode_q_i=0, or ctrl_mode_q_i=1 with start_i=1.
REQ-019 On the first clock in RUN: presc_cnt=0, pat_subcycle_cnt_o=0, pat_sync_o=1, busy_o=1; latency from the trigger edge SHALL be exactly one clock.
REQ-020 In RUN, presc_cnt SHALL increment each clock and wrap to 0 after reaching presc_shadow.
REQ-021 At a presc_cnt wrap, pat_subcycle_cnt_o SHALL increment, or wrap to 0 if it equals sub_shadow (end of cycle).
REQ-022 pat_sync_o SHALL be registered and high only on the clock where presc_cnt=0 and pat_subcycle_cnt_o=0; one pattern cycle lasts (presc+1)*(subcycles+1) clocks.
REQ-023 cfg_presc_q_i, cfg_subcycles_q_i and cfg_frames_q_i SHALL be captured into shadow registers on entry to RUN and at each end of cycle; changes mid-cycle SHALL have no effect until the next cycle.
REQ-024 At each end of cycle, frame_cnt_o SHALL increment; in continuous mode it SHALL wrap modulo 2^FRAME_WIDTH.
REQ-025 Burst mode: at the end of cycle where frame_cnt_o equals frames_shadow, the state SHALL go RUN->DONE, with no further pat_sync_o.
REQ-026 DONE SHALL last one clock with done_o=1 and busy_o=0, then go to IDLE; frame_cnt_o SHALL hold its final value through DONE and clear in IDLE.
REQ-027 start_i during RUN or DONE SHALL be ignored (no restart, no queueing).
REQ-028 ctrl_en_q_i=0 in RUN or DONE SHALL force IDLE on the next clock, clear all counters, and produce no done_o.
REQ-029 ctrl_mode_q_i SHALL be sampled only in IDLE; a change during RUN takes effect from the next run.
REQ-030 cfg_presc_q_i=0 SHALL give one-clock subcycles; cfg_subcycles_q_i=0 SHALL give pat_sync_o every presc+1 clocks; all-zero config SHALL give pat_sync_o high on every clock in RUN.

Reset
REQ-031 With rst_n low, all outputs and state SHALL be 0/IDLE immediately, independent of clk.
REQ-032 Reset asserted mid-RUN SHALL abort without a done_o pulse; after release the block SHALL wait in IDLE for a trigger per REQ-018.

Verification
REQ-033 Continuous, presc=1, subcycles=2, en=1: pat_sync_o every 6 clocks; pat_subcycle_cnt_o reads 0,0,1,1,2,2; frame_cnt_o = 1,2,3 at successive cycle ends.
REQ-034 Burst, presc=0, subcycles=3, frames=1, start_i pulse: exactly 2 pat_sync_o pulses 4 clocks apart; done_o high 8 clocks after first busy_o clock; then IDLE.
REQ-035 Write presc 1->4 in the middle of cycle 0 (continuous, subcycles=0): cycle 0 keeps period 2, cycle 1 onward has period 5.
REQ-036 Burst running with frames=3; drop ctrl_en_q_i after 2 cycles: next clock busy_o=0, counters 0, no done_o; a start_i during the run is ignored.
REQ-037 Assert rst_n low mid-subcycle with presc=7: outputs 0 asynchronously; after release with en=1 in continuous mode, pat_sync_o one clock after the first enabled clock edge.
REQ-038 All-zero config, continuous: pat_sync_o=1 and pat_subcycle_cnt_o=0 on every RUN clock; frame_cnt_o increments every clock and wraps.
